// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU pipeline control logic: FSM encoding and
// register-index constants used by the hazard controller and forwarding unit.
package cpu_ctrl_pkg;

    localparam int REG_W_DEFAULT = 5;
    localparam int REG_ZERO      = 0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: stage status in, per-register control out.
interface pipe_hazard_ctrl_if
#(
    parameter int REG_W = cpu_ctrl_pkg::REG_W_DEFAULT
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rt;
    logic             ex_branch_taken;
    logic             dmem_req;
    logic             dmem_ack;

    logic             pc_write;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_hold;

    // The pipeline datapath reports stage status and obeys the controls.
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
               ex_branch_taken, dmem_req, dmem_ack,
        input  pc_write, ifid_stall, ifid_flush, idex_bubble, exmem_hold
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
               ex_branch_taken, dmem_req, dmem_ack,
        output pc_write, ifid_stall, ifid_flush, idex_bubble, exmem_hold
    );
endinterface

// File: rtl/lu_detect.sv
// Load-use hazard detector: the instruction in ID reads the register a load in
// EX is about to write. Purely combinational so the forwarding unit can reuse it.
module lu_detect
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT
)
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    output logic             lu_hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt == id_rs);
    assign rt_match = id_uses_rt & (ex_rt == id_rt);

    // Writes to the zero register are discarded, so they never create a hazard.
    assign lu_hazard = ex_memread & (ex_rt != REG_W'(REG_ZERO)) & id_valid
                     & (rs_match | rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline control: PC / IF/ID / ID/EX / EX/MEM advance, hold,
// flush and bubble decisions, plus memory-timeout flag and stall counter.
module pipe_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_W    = REG_W_DEFAULT,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4,
    parameter int CNT_W    = 16
)
(
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  bus,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   stall_cnt
);

    fsm_state_t        fsm_reg;
    fsm_state_t        fsm_next;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic              timeout_err_reg;
    logic              timeout_err_next;
    logic [CNT_W-1:0]  stall_cnt_reg;

    logic lu_hazard;
    logic mem_block;
    logic branch;

    logic pc_write_c;
    logic stall_c;
    logic flush_c;
    logic bubble_c;
    logic hold_c;

    lu_detect #(
        .REG_W (REG_W)
    ) u_lu_detect (
        .id_valid   (bus.id_valid),
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .id_uses_rt (bus.id_uses_rt),
        .ex_memread (bus.ex_memread),
        .ex_rt      (bus.ex_rt),
        .lu_hazard  (lu_hazard)
    );

    assign branch    = bus.ex_branch_taken;
    assign mem_block = bus.dmem_req & ~bus.dmem_ack;

    // The flush is built only from fsm and the branch so no glitch on the
    // memory handshake can reach the level-sensitive IF/ID clear. During a
    // freeze a taken branch therefore clears IF/ID early; that instruction is
    // on the wrong path anyway, and the hold on IF/ID yields to the clear.
    assign flush_c = branch & (fsm_reg != ERR);

    always_comb begin
        fsm_next         = fsm_reg;
        wait_cnt_next    = wait_cnt_reg;
        timeout_err_next = timeout_err_reg;
        pc_write_c       = 1'b1;
        stall_c          = 1'b0;
        bubble_c         = 1'b0;
        hold_c           = 1'b0;

        case (fsm_reg)
            RUN: begin
                if (mem_block) begin
                    pc_write_c    = 1'b0;
                    stall_c       = 1'b1;
                    hold_c        = 1'b1;
                    fsm_next      = MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end else if (branch) begin
                    bubble_c = 1'b1;
                end else if (lu_hazard) begin
                    pc_write_c = 1'b0;
                    stall_c    = 1'b1;
                    bubble_c   = 1'b1;
                end
            end

            MEM_WAIT: begin
                if (bus.dmem_ack) begin
                    // Access completes: resolve whatever was frozen in EX/ID.
                    if (branch) begin
                        bubble_c = 1'b1;
                    end else if (lu_hazard) begin
                        pc_write_c = 1'b0;
                        stall_c    = 1'b1;
                        bubble_c   = 1'b1;
                    end
                    fsm_next      = RUN;
                    wait_cnt_next = '0;
                end else begin
                    pc_write_c = 1'b0;
                    stall_c    = 1'b1;
                    hold_c     = 1'b1;
                    if (wait_cnt_reg == WAIT_W'(MAX_WAIT)) begin
                        fsm_next         = ERR;
                        timeout_err_next = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                    end
                end
            end

            default: begin
                pc_write_c = 1'b0;
                stall_c    = 1'b1;
                bubble_c   = 1'b1;
                hold_c     = 1'b1;
                fsm_next   = ERR;
            end
        endcase
    end

    // Reset forces a safe pipeline: PC held, IF/ID cleared, NOP into ID/EX.
    assign bus.pc_write    = rst_n & pc_write_c;
    assign bus.ifid_stall  = rst_n & stall_c & ~flush_c;
    assign bus.ifid_flush  = ~rst_n | flush_c;
    assign bus.idex_bubble = ~rst_n | bubble_c;
    assign bus.exmem_hold  = rst_n & hold_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg         <= RUN;
            wait_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
            stall_cnt_reg   <= '0;
        end else begin
            fsm_reg         <= fsm_next;
            wait_cnt_reg    <= wait_cnt_next;
            timeout_err_reg <= timeout_err_next;
            if (!pc_write_c && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign timeout_err = timeout_err_reg;
    assign stall_cnt   = stall_cnt_reg;

endmodule
